// File: rtl/gpio_mulpop_pkg.sv
// rtl/gpio_mulpop_pkg.sv - shared FSM states, default register map and CTRL bit positions
package gpio_mulpop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] DEF_ADDR_A1   = 16'h0380;
  localparam logic [15:0] DEF_ADDR_A2   = 16'h0388;
  localparam logic [15:0] DEF_ADDR_W    = 16'h0390;
  localparam logic [15:0] DEF_ADDR_L    = 16'h0398;
  localparam logic [15:0] DEF_ADDR_CTRL = 16'h03A0;

  // Status word layout returned by a CTRL read
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_VALID = 2;
  localparam int CTRL_ERR   = 3;

endpackage

// File: rtl/gpio_mulpop_popcount.sv
// rtl/gpio_mulpop_popcount.sv - popcount_n: number of set bits in an N-bit word
module popcount_n #(
  parameter int N = 32
) (
  input  logic [N-1:0]               data,
  output logic [$clog2(N+1)-1:0]     count
);

  localparam int CW = $clog2(N + 1);

  // Ripple sum of the individual bits
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/gpio_mulpop.sv
// rtl/gpio_mulpop.sv - sequential multiply then popcount peripheral; popcount built only with MULPOP_POPCNT_EN
module gpio_mulpop
  import gpio_mulpop_pkg::*;
#(
  parameter int          OPERAND_W = 24,
  parameter int          RESULT_W  = 32,
  parameter logic [15:0] ADDR_A1   = DEF_ADDR_A1,
  parameter logic [15:0] ADDR_A2   = DEF_ADDR_A2,
  parameter logic [15:0] ADDR_W    = DEF_ADDR_W,
  parameter logic [15:0] ADDR_L    = DEF_ADDR_L,
  parameter logic [15:0] ADDR_CTRL = DEF_ADDR_CTRL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        swr,
  input  logic        srd,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic [31:0] gpio_out
);

  localparam int PROD_W = 2 * OPERAND_W;
  localparam int CNT_W  = $clog2(OPERAND_W + 1);
  localparam int POP_W  = $clog2(RESULT_W + 1);

  state_t                state;
  logic [OPERAND_W-1:0]  a1;
  logic [OPERAND_W-1:0]  a2;
  logic [OPERAND_W-1:0]  mplier;
  logic [PROD_W-1:0]     mcand;
  logic [PROD_W-1:0]     product;
  logic [CNT_W-1:0]      bit_cnt;
  logic [RESULT_W-1:0]   w;
  logic [POP_W-1:0]      l;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  valid;
  logic [15:0]           op_count;

  logic                  wr_ctrl;
  logic [RESULT_W-1:0]   prod_low;
  logic                  prod_fits;
  logic [POP_W-1:0]      pop;
  logic                  unused_in;

  assign wr_ctrl   = swr && (saddress == ADDR_CTRL);
  assign prod_low  = product[RESULT_W-1:0];
  // Shifting by the full width yields zero, so equal widths always fit
  assign prod_fits = ((product >> RESULT_W) == '0);
  assign unused_in = ^sdata_in;

`ifdef MULPOP_POPCNT_EN
  popcount_n #(.N(RESULT_W)) u_popcount (
    .data  (prod_low),
    .count (pop)
  );
`else
  assign pop = '0;
`endif

  assign gpio_out = {16'h0000, op_count};

  // Operand registers: writes land any time, only the next start consumes them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1 <= '0;
      a2 <= '0;
    end else if (swr) begin
      if (saddress == ADDR_A1) a1 <= sdata_in[OPERAND_W-1:0];
      if (saddress == ADDR_A2) a2 <= sdata_in[OPERAND_W-1:0];
    end
  end

  // Control FSM: shift-add multiply, result capture, completion bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      product  <= '0;
      bit_cnt  <= '0;
      w        <= '0;
      l        <= '0;
      valid    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      op_count <= '0;
    end else begin
      if (wr_ctrl && busy) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (wr_ctrl) begin
            mcand   <= PROD_W'(a1);
            mplier  <= a2;
            product <= '0;
            bit_cnt <= CNT_W'(OPERAND_W - 1);
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_MULT;
          end
        end
        ST_MULT: begin
          if (mplier[0]) product <= product + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) state <= ST_COUNT;
        end
        ST_COUNT: begin
          w     <= prod_low;
          valid <= prod_fits;
          l     <= pop;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          op_count <= op_count + 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered read port; sees status from before any same-cycle write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdata_out <= '0;
    end else if (srd) begin
      case (saddress)
        ADDR_W:    sdata_out <= 32'(w);
        ADDR_L:    sdata_out <= 32'(l);
        ADDR_CTRL: sdata_out <= {28'h0, err, valid, done, busy};
        default:   sdata_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_mulpop.sv
// tb/tb_gpio_mulpop.sv - self-checking bench for gpio_mulpop with a result-level model
module tb_gpio_mulpop;

  localparam logic [15:0] A_A1   = 16'h0380;
  localparam logic [15:0] A_A2   = 16'h0388;
  localparam logic [15:0] A_W    = 16'h0390;
  localparam logic [15:0] A_L    = 16'h0398;
  localparam logic [15:0] A_CTRL = 16'h03A0;
  localparam int          LATENCY = 26;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] saddress = '0;
  logic        swr = 1'b0;
  logic        srd = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_out;

  int errors = 0;
  int checks = 0;
  int busy_cycles;

  gpio_mulpop dut (
    .clk       (clk),
    .reset     (reset),
    .saddress  (saddress),
    .swr       (swr),
    .srd       (srd),
    .sdata_in  (sdata_in),
    .sdata_out (sdata_out),
    .gpio_out  (gpio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result-level model: product by plain multiplication, fixed latency window
  logic [23:0] m_a1, m_a2;
  logic [63:0] m_prod;
  int          m_left;
  logic [31:0] m_w;
  logic [5:0]  m_l;
  logic        m_valid, m_done, m_err;
  logic [15:0] m_cnt;
  logic [31:0] m_sdata;
  logic        m_preload = 1'b0;
  wire         m_busy = (m_left != 0);

  function automatic logic [31:0] model_read(input logic [15:0] a);
    case (a)
      A_W:     return m_w;
      A_L:     return 32'(m_l);
      A_CTRL:  return {28'h0, m_err, m_valid, m_done, m_busy};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a1 <= '0; m_a2 <= '0; m_prod <= '0; m_left <= 0;
      m_w <= '0; m_l <= '0; m_valid <= 1'b1; m_done <= 1'b0; m_err <= 1'b0;
      m_cnt <= '0; m_sdata <= '0;
    end else begin
      if (srd) m_sdata <= model_read(saddress);
      if (swr && saddress == A_A1) m_a1 <= sdata_in[23:0];
      if (swr && saddress == A_A2) m_a2 <= sdata_in[23:0];
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 2) begin
          m_w     <= m_prod[31:0];
          m_valid <= (m_prod[63:32] == 32'h0);
`ifdef MULPOP_POPCNT_EN
          m_l     <= 6'($countones(m_prod[31:0]));
`else
          m_l     <= 6'd0;
`endif
        end
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_cnt  <= m_cnt + 16'd1;
        end
        if (swr && saddress == A_CTRL) m_err <= 1'b1;
      end else if (swr && saddress == A_CTRL) begin
        m_prod <= 64'(m_a1) * 64'(m_a2);
        m_left <= LATENCY;
        m_done <= 1'b0;
        m_err  <= 1'b0;
      end
      if (m_preload) m_cnt <= 16'hFFFE;
    end
  end

  // Every cycle: read data and counter must follow the model
  always @(negedge clk) begin
    chk("sdata_out_vs_model", sdata_out, m_sdata);
    chk("gpio_out_vs_model", gpio_out, {16'h0, m_cnt});
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(posedge clk);
    #1 swr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    saddress = a; srd = 1'b1;
    @(posedge clk);
    #1 srd = 1'b0;
    chk(name, sdata_out, exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      saddress = A_CTRL; srd = 1'b1;
      @(posedge clk);
      #1 srd = 1'b0;
      n++;
    end while (sdata_out[0] && n < 100);
    chk("wait_idle_timeout", 32'(sdata_out[0]), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_sdata_out", sdata_out, 32'h0);
    chk("reset_gpio_out", gpio_out, 32'h0);
    reset = 1'b0;
    rd(A_CTRL, 32'h4, "reset_ctrl");
    rd(A_W, 32'h0, "reset_w");

    // 3 * 5 with a same-cycle status read and busy window measurement
    wr(A_A1, 32'd3);
    wr(A_A2, 32'd5);
    @(negedge clk);
    saddress = A_CTRL; sdata_in = 32'h0; swr = 1'b1; srd = 1'b1;
    @(posedge clk);
    #1 swr = 1'b0;
    chk("ctrl_pre_start", sdata_out, 32'h4);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (sdata_out[0]) busy_cycles++;
    end
    srd = 1'b0;
    chk("busy_cycles", 32'(busy_cycles), 32'd26);
    rd(A_W, 32'd15, "w_3x5");
`ifdef MULPOP_POPCNT_EN
    rd(A_L, 32'd4, "l_3x5");
`else
    rd(A_L, 32'd0, "l_3x5_disabled");
`endif
    rd(A_CTRL, 32'h6, "ctrl_3x5");
    chk("gpio_after_1", gpio_out, 32'd1);

    // Full-scale operands overflow the visible result
    wr(A_A1, 32'hFFFFFF);
    wr(A_A2, 32'hFFFFFF);
    wr(A_CTRL, 32'h0);
    wait_idle();
    rd(A_W, 32'hFE000001, "w_max");
`ifdef MULPOP_POPCNT_EN
    rd(A_L, 32'd8, "l_max");
`endif
    rd(A_CTRL, 32'h2, "ctrl_max");
    chk("gpio_after_2", gpio_out, 32'd2);

    // Start while busy: err set, running result kept, operand write deferred
    wr(A_A1, 32'd7);
    wr(A_A2, 32'd6);
    wr(A_CTRL, 32'h0);
    wr(A_A1, 32'd9);
    repeat (3) @(posedge clk);
    wr(A_CTRL, 32'h0);
    wait_idle();
    rd(A_W, 32'd42, "w_7x6");
    rd(A_CTRL, 32'hE, "ctrl_err");
    chk("gpio_after_3", gpio_out, 32'd3);
    wr(A_CTRL, 32'h8);
    wait_idle();
    rd(A_CTRL, 32'h6, "ctrl_err_cleared");
    rd(A_W, 32'd54, "w_9x6");
    chk("gpio_after_4", gpio_out, 32'd4);

    // Reset in the middle of MULT
    wr(A_CTRL, 32'h0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midop_reset_sdata", sdata_out, 32'h0);
    chk("midop_reset_gpio", gpio_out, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(A_W, 32'h0, "post_reset_w");
    rd(A_L, 32'h0, "post_reset_l");
    rd(A_CTRL, 32'h4, "post_reset_ctrl");
    wr(A_A1, 32'd3);
    wr(A_A2, 32'd5);
    wr(A_CTRL, 32'h0);
    wait_idle();
    rd(A_W, 32'd15, "post_reset_w_3x5");
    chk("post_reset_gpio", gpio_out, 32'd1);

    // Counter wrap: jump ahead to 0xFFFE, then two more operations
    @(negedge clk);
    m_preload = 1'b1;
    @(posedge clk);
    #1 m_preload = 1'b0;
    force dut.op_count = 16'hFFFE;
    #1 release dut.op_count;
    wr(A_CTRL, 32'h0);
    wait_idle();
    chk("gpio_ffff", gpio_out, 32'h0000FFFF);
    wr(A_CTRL, 32'h0);
    wait_idle();
    chk("gpio_wrap", gpio_out, 32'h00000000);
    rd(16'h0400, 32'h0, "unmapped_read");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
